// File: rtl/control_fsm.sv
// Multicycle MIPS main control: Moore FSM driving datapath enables/selects,
// plus a retired-instruction counter for debug.
module control_fsm #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    output logic             pc_w,
    output logic             pc_w_cond,
    output logic             i_or_d,
    output logic             mem_r,
    output logic             mem_w,
    output logic             ir_w,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_w,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             pc_w_en,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef struct packed {
        logic       pc_w;
        logic       pc_w_cond;
        logic       i_or_d;
        logic       mem_r;
        logic       mem_w;
        logic       ir_w;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_w;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.mem_r = 1'b1; c.ir_w = 1'b1; c.alu_src_b = 2'b01; c.pc_w = 1'b1;
            end
            DECODE:    c.alu_src_b = 2'b11;
            MEM_ADDR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            MEM_READ:  begin c.mem_r = 1'b1; c.i_or_d = 1'b1; end
            MEM_WB:    begin c.reg_w = 1'b1; c.mem_to_reg = 1'b1; end
            MEM_WRITE: begin c.mem_w = 1'b1; c.i_or_d = 1'b1; end
            R_EXEC:    begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            R_WB:      begin c.reg_w = 1'b1; c.reg_dst = 1'b1; end
            BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_w_cond = 1'b1; c.pc_src = 2'b01;
            end
            JUMP:      begin c.pc_w = 1'b1; c.pc_src = 2'b10; end
            ADDI_EXEC: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            ADDI_WB:   c.reg_w = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [5:0] op);
        case (s)
            FETCH: return DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: return MEM_ADDR;
                    OP_RTYPE:     return R_EXEC;
                    OP_BEQ:       return BRANCH;
                    OP_J:         return JUMP;
                    OP_ADDI:      return ADDI_EXEC;
                    default:      return FETCH;
                endcase
            end
            MEM_ADDR:  return (op == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  return MEM_WB;
            R_EXEC:    return R_WB;
            ADDI_EXEC: return ADDI_WB;
            default:   return FETCH;
        endcase
    endfunction

    function automatic logic retires(input state_t s);
        return (s == MEM_WB) || (s == MEM_WRITE) || (s == R_WB) ||
               (s == BRANCH) || (s == JUMP) || (s == ADDI_WB);
    endfunction

    always_comb begin
        state_d = next_of(state_q, opcode);
    end

    // Outputs are registered from the next-state decode, so ctrl_q always
    // equals the Moore decode of state_q without a combinational output path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ctrl_q  <= decode(FETCH);
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
            if (retires(state_q)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign pc_w        = ctrl_q.pc_w;
    assign pc_w_cond   = ctrl_q.pc_w_cond;
    assign i_or_d      = ctrl_q.i_or_d;
    assign mem_r       = ctrl_q.mem_r;
    assign mem_w       = ctrl_q.mem_w;
    assign ir_w        = ctrl_q.ir_w;
    assign mem_to_reg  = ctrl_q.mem_to_reg;
    assign reg_dst     = ctrl_q.reg_dst;
    assign reg_w       = ctrl_q.reg_w;
    assign alu_src_a   = ctrl_q.alu_src_a;
    assign alu_src_b   = ctrl_q.alu_src_b;
    assign alu_op      = ctrl_q.alu_op;
    assign pc_src      = ctrl_q.pc_src;
    assign pc_w_en     = ctrl_q.pc_w | (ctrl_q.pc_w_cond & zero);
    assign state       = state_q;
    assign illegal_op  = (state_q == DECODE) && !is_legal(opcode);
    assign instr_count = count_q;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-instruction state paths and per-state
// output table feed a queue; a negedge monitor checks two DUT instances.
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;

    logic        pc_w, pc_w_cond, i_or_d, mem_r, mem_w, ir_w, mem_to_reg, reg_dst, reg_w, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic        pc_w_en, illegal_op;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        s_pc_w, s_pc_w_cond, s_i_or_d, s_mem_r, s_mem_w, s_ir_w, s_mem_to_reg, s_reg_dst;
    logic        s_reg_w, s_alu_src_a, s_pc_w_en, s_illegal_op;
    logic [1:0]  s_alu_src_b, s_alu_op, s_pc_src;
    logic [3:0]  s_state;
    logic [3:0]  s_instr_count;

    control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .pc_w(pc_w), .pc_w_cond(pc_w_cond), .i_or_d(i_or_d), .mem_r(mem_r), .mem_w(mem_w),
        .ir_w(ir_w), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_w(reg_w),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_w_en(pc_w_en), .state(state), .illegal_op(illegal_op), .instr_count(instr_count)
    );

    control_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .pc_w(s_pc_w), .pc_w_cond(s_pc_w_cond), .i_or_d(s_i_or_d), .mem_r(s_mem_r), .mem_w(s_mem_w),
        .ir_w(s_ir_w), .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst), .reg_w(s_reg_w),
        .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .pc_src(s_pc_src),
        .pc_w_en(s_pc_w_en), .state(s_state), .illegal_op(s_illegal_op), .instr_count(s_instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [15:0] ctrl;
        logic        pc_en;
        logic        ill;
        int          cnt;
    } exp_t;

    typedef int path_t[$];

    exp_t scb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 1'b0;
    int   exp_count = 0;

    // Bit order: pc_w,pc_w_cond,i_or_d,mem_r,mem_w,ir_w,mem_to_reg,reg_dst,reg_w,alu_src_a,alu_src_b,alu_op,pc_src
    function automatic logic [15:0] spec_ctrl(input int s);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb2, op2, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb2 = 2'b00; op2 = 2'b00; ps = 2'b00;
        case (s)
            0:  begin mr = 1; irw = 1; sb2 = 2'b01; pw = 1; end
            1:  sb2 = 2'b11;
            2:  begin sa = 1; sb2 = 2'b10; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 1; op2 = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; op2 = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb2 = 2'b10; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb2, op2, ps};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    function automatic path_t path_of(input logic [5:0] op);
        path_t p;
        case (op)
            6'b100011: p = '{0, 1, 2, 3, 4};
            6'b101011: p = '{0, 1, 2, 5};
            6'b000000: p = '{0, 1, 6, 7};
            6'b001000: p = '{0, 1, 10, 11};
            6'b000100: p = '{0, 1, 8};
            6'b000010: p = '{0, 1, 9};
            default:   p = '{0, 1};
        endcase
        return p;
    endfunction

    function automatic void push_exp(input int st, input bit ill);
        exp_t e;
        e.st    = st;
        e.ctrl  = spec_ctrl(st);
        e.pc_en = e.ctrl[15] | (e.ctrl[14] & zero);
        e.ill   = ill;
        e.cnt   = exp_count;
        scb.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t m;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (scb.size() == 0) begin
                    chk("scoreboard_underflow", 32'd1, 32'd0);
                end else begin
                    m = scb.pop_front();
                    chk("state", 32'(state), 32'(m.st));
                    chk("ctrl", 32'({pc_w, pc_w_cond, i_or_d, mem_r, mem_w, ir_w, mem_to_reg,
                                     reg_dst, reg_w, alu_src_a, alu_src_b, alu_op, pc_src}), 32'(m.ctrl));
                    chk("pc_w_en", 32'(pc_w_en), 32'(m.pc_en));
                    chk("illegal_op", 32'(illegal_op), 32'(m.ill));
                    chk("instr_count", instr_count, 32'(m.cnt));
                    chk("state_w4", 32'(s_state), 32'(m.st));
                    chk("instr_count_w4", 32'(s_instr_count), 32'(m.cnt % 16));
                end
            end
        end
    end

    // Entry point is #1 after the edge that starts this instruction's FETCH.
    task automatic run_instr(input logic [5:0] op, input int zsel, input int abort_at);
        path_t p;
        p = path_of(op);
        for (int i = 0; i < p.size(); i++) begin
            zero = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
            if (i == abort_at) rst_n = 1'b0;
            push_exp(p[i], (p[i] == 1) && !legal(op));
            if (p[i] == 0) begin
                @(negedge clk);
                #1 opcode = op;
            end
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                rst_n = 1'b1;
                exp_count = 0;
                return;
            end
        end
        if (legal(op)) exp_count++;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_count = 0;
        mon_on = 1'b1;
        for (int i = 1; i < cycles; i++) begin
            zero = 1'($urandom_range(0, 1));
            opcode = 6'($urandom);
            push_exp(0, 1'b0);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

        do_reset(3);
        run_instr(6'b100011, 2, -1);
        run_instr(6'b101011, 2, -1);
        run_instr(6'b000000, 2, -1);
        run_instr(6'b001000, 2, -1);
        run_instr(6'b000010, 2, -1);
        run_instr(6'b000100, 1, -1);
        run_instr(6'b000100, 0, -1);
        run_instr(6'b111111, 2, -1);
        run_instr(6'b100011, 2, 3);
        for (int n = 0; n < 20; n++) run_instr(6'b000010, 2, -1);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 5)];
            else                           op = 6'($urandom);
            run_instr(op, 2, ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        mon_on = 1'b0;
        chk("scoreboard_drained", 32'(scb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle main control unit for the MIPS datapath. It sits directly downstream of the instruction register and consumes its 6-bit `opcode` field. It drives the datapath write enables and mux selects, including `ir_w` back to the instruction register, through a Moore state machine. It also keeps a retired-instruction counter for debug.

## Interface

Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single system clock. All state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `opcode`  in  6: instruction opcode from the instruction register. Valid from the DECODE state onward.
- `zero`  in  1: ALU zero flag, used in BRANCH.
- `pc_w`  out  1: unconditional PC write.
- `pc_w_cond`  out  1: PC write qualified by `zero`.
- `i_or_d`  out  1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_r`  out  1: memory read.
- `mem_w`  out  1: memory write.
- `ir_w`  out  1: instruction register load enable.
- `mem_to_reg`  out  1: register write-data select. 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1: destination register select. 0 = rt, 1 = rd.
- `reg_w`  out  1: register file write.
- `alu_src_a`  out  1: ALU A select. 0 = PC, 1 = A.
- `alu_src_b`  out  2: ALU B select. 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `alu_op`  out  2: ALU operation class. 00 = add, 01 = subtract, 10 = decode by funct, 11 = reserved.
- `pc_src`  out  2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pc_w_en`  out  1: combined PC enable, `pc_w | (pc_w_cond & zero)`.
- `state`  out  4: current state encoding, for debug.
- `illegal_op`  out  1: one-cycle pulse when an unsupported opcode is decoded.
- `instr_count`  out  CNT_W: count of retired instructions.

## Operation

Opcodes:
- R-type = 000000
- LW = 100011
- SW = 101011
- BEQ = 000100
- J = 000010
- ADDI = 001000

States, with their encodings and asserted outputs. Any signal not listed is 0 in that state.
- FETCH (0): `mem_r=1`, `ir_w=1`, `alu_src_b=01`, `pc_w=1`, `pc_src=00`. Goes to DECODE.
- DECODE (1): `alu_src_b=11`, computing the branch target. Next state by opcode:
  - LW or SW → MEM_ADDR
  - R-type → R_EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDI_EXEC
  - any other opcode → FETCH, with `illegal_op=1` for this cycle.
- MEM_ADDR (2): `alu_src_a=1`, `alu_src_b=10`. LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ (3): `mem_r=1`, `i_or_d=1`. Goes to MEM_WB.
- MEM_WB (4): `reg_w=1`, `mem_to_reg=1`, `reg_dst=0`. Goes to FETCH.
- MEM_WRITE (5): `mem_w=1`, `i_or_d=1`. Goes to FETCH.
- R_EXEC (6): `alu_src_a=1`, `alu_src_b=00`, `alu_op=10`. Goes to R_WB.
- R_WB (7): `reg_w=1`, `reg_dst=1`, `mem_to_reg=0`. Goes to FETCH.
- BRANCH (8): `alu_src_a=1`, `alu_src_b=00`, `alu_op=01`, `pc_w_cond=1`, `pc_src=01`. Goes to FETCH.
- JUMP (9): `pc_w=1`, `pc_src=10`. Goes to FETCH.
- ADDI_EXEC (10): `alu_src_a=1`, `alu_src_b=10`, `alu_op=00`. Goes to ADDI_WB.
- ADDI_WB (11): `reg_w=1`, `reg_dst=0`, `mem_to_reg=0`. Goes to FETCH.
- Encodings 12–15 are unreachable. If reached, the next state is FETCH and no write enable is asserted.

Outputs:
- All datapath outputs are Moore outputs decoded from the state register only. The exception is `pc_w_en`, which also depends on `zero`.
- `illegal_op` is decoded from DECODE and `opcode`.

Retired-instruction counter:
- `instr_count` increments by 1 on each transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB.
- A BEQ counts as retired whether or not the branch is taken.
- Illegal-opcode returns do not increment the counter.
- The counter wraps modulo 2^CNT_W, with no saturation.

## Timing

- Reset (`rst_n=0` at a rising edge): next state is FETCH and `instr_count` is 0. All outputs then take their FETCH values, so `ir_w=1`, `mem_r=1` and `pc_w=1` are asserted during reset. Reset overrides any in-progress instruction.
- The instruction register loads on the falling edge of `clk`. `ir_w` is high for all of FETCH, so the new opcode is stable at the FETCH/DECODE rising edge and `opcode` is valid throughout DECODE. The FSM must not sample `opcode` in FETCH.
- `opcode` is held stable from DECODE to the end of the instruction because `ir_w=0` outside FETCH. MEM_ADDR may re-read it to select LW or SW.
- Cycle counts, FETCH through the last state: LW 5, SW 4, R-type 4, ADDI 4, BEQ 3, J 3. An illegal opcode takes 2 cycles.
- `zero` is used combinationally only in BRANCH, via `pc_w_en`.

## Test plan

- Reset: hold `rst_n=0` for 3 cycles, then release → `state=0`, `instr_count=0`, `ir_w=1`, `pc_w_en=1`; `state=1` on the next edge.
- LW: `opcode=100011` → states 0,1,2,3,4,0; `reg_w` and `mem_to_reg` both 1 only in state 4; `instr_count` goes from 0 to 1 on entry to FETCH.
- Mixed program: SW, R-type, ADDI, J back to back → state sequences 0,1,2,5 / 0,1,6,7 / 0,1,10,11 / 0,1,9; `instr_count=4` after 15 cycles.
- BEQ with `zero=1`, then BEQ with `zero=0` → `pc_w_en=1` in BRANCH only for the first; both retire, so `instr_count=2`.
- Illegal `opcode=111111` → DECODE then FETCH; `illegal_op` high for exactly 1 cycle; `instr_count` unchanged; no `reg_w` or `mem_w` asserted.
- `rst_n=0` asserted while in MEM_READ → FETCH on the next edge, `mem_w=reg_w=0`, `instr_count=0`. With `CNT_W=4`, 16 retired instructions → counter wraps to 0.
